stream_demux: RTL and testbench
===============================

// Module: stream_demux
// PURPOSE
//  1:N packet router; the fan-out counterpart of the N:1 round-robin arbiter.
//  - Accepts one valid/ready stream carrying data, a destination index and an end-of-packet flag.
//  - Steers each whole packet to exactly one of REQ_WIDTH downstream ports.
//  - Sits between a shared bus/link and per-requester consumers.
//  - Registered in both directions, so it breaks ready and data timing paths.
// PARAMETERS
//  REQ_WIDTH  4   number of output ports (>=2)
//  DW         8   data width per beat
//  DEST_W     2   destination index width; must equal max(1,$clog2(REQ_WIDTH))
//  CNT_W      8   width of dropped-packet counter (saturating)
// PORTS
//  clk        in   1              rising-edge clock
//  rst        in   1              asynchronous, active-high reset
//  valid_in   in   1              upstream beat valid
//  ready_out  out  1              upstream ready; registered (~skid_full & ~rst)
//  data_in    in   DW             upstream beat data
//  dest_in    in   DEST_W         destination port; sampled on the first beat of a packet only
//  last_in    in   1              final beat of packet
//  valid_out  out  REQ_WIDTH      one-hot valid towards the selected port; all 0 when idle
//  ready_in   in   REQ_WIDTH      per-port downstream ready
//  data_out   out  DW             beat data, shared by all ports
//  last_out   out  1              final beat flag, qualified by |valid_out
//  drop_cnt   out  CNT_W          count of packets dropped for illegal dest; saturates at all-ones
// BEHAVIOUR
//  Reset (async, rst=1):
//   - ready_out=0, valid_out=0, data_out=0, last_out=0, drop_cnt=0.
//   - FSM=IDLE; skid and output registers empty.
//   - First cycle after release: ready_out=1.
//  Handshakes:
//   - Upstream transfer when valid_in & ready_out.
//   - Downstream transfer on port d when valid_out[d] & ready_in[d].
//   - ready_in of unselected ports is ignored.
//   - valid_out, data_out, last_out hold stable until their transfer completes; no retraction.
//  Input skid buffer:
//   - 2 entries {dest,last,data}: main plus skid.
//   - Beat lands in skid when main is occupied and cannot advance.
//   - ready_out deasserts the cycle after skid fills.
//   - Sustained throughput is 1 beat/cycle when the selected sink holds ready_in=1.
//  Latency: beat accepted in cycle t appears on valid_out in cycle t+1 (output stage empty or draining).
//  FSM (advances when a beat moves from the skid stage to the output stage):
//   - IDLE, dest<REQ_WIDTH: latch dest into sel_q and forward the beat.
//     last=1 -> stay IDLE; last=0 -> BUSY.
//   - IDLE, dest>=REQ_WIDTH: discard the beat and increment drop_cnt once (saturating).
//     last=1 -> stay IDLE; last=0 -> DROP.
//   - BUSY: forward beats to sel_q; dest field ignored; beat with last=1 -> IDLE.
//   - DROP: consume one beat per cycle, never presented downstream; beat with last=1 -> IDLE.
//  Boundaries:
//   - Single-beat packets back-to-back to different ports run at 1/cycle with no bubble.
//   - Sink stall: output stage holds; skid absorbs one beat; then ready_out=0.
//   - Sink ready toggling every cycle: no beat duplicated or lost; order preserved.
//   - Reset mid-packet: partial packet discarded, FSM=IDLE, no further valid_out for it.
//   - drop_cnt at all-ones stays all-ones.
//  Widths: valid_out = out_valid ? (1<<sel_q) : 0, computed in REQ_WIDTH bits; dest compare is unsigned.
// STRUCTURE
//  - Shared package: state encoding localparams (ST_IDLE, ST_BUSY, ST_DROP) and the DEST_W function.
//    The arbiter uses the same package.
//  - Sub-module skid_buffer #(W=DEST_W+1+DW): 2-entry, registered ready, reusable for the arbiter output.
//  - Top holds the FSM, output register, one-hot decode and drop counter.
// TESTING
//  1. Reset, then 1-beat pkt dest=2 data=8'hA5 last=1, all ready_in=1
//     -> cycle+1: valid_out=4'b0100, data_out=A5, last_out=1; drop_cnt=0.
//  2. 3-beat pkt dest=1 data 11,22,33; dest_in changed to 3 on beats 2-3
//     -> all beats on valid_out=4'b0010 in order; last_out only with 33.
//  3. Ready_in[0]=0 for 5 cycles while streaming 4 beats to port 0
//     -> ready_out=0 after 2 beats buffered; on release all 4 delivered once, in order.
//  4. REQ_WIDTH=3, pkt dest=3 with 2 beats, then pkt dest=0 data=77
//     -> drop_cnt=1, valid_out never set for dropped beats; 77 delivered on port 0.
//  5. Assert rst mid 4-beat pkt after beat 2
//     -> outputs 0 immediately; next pkt dest=3 routes correctly from IDLE.
//  6. 300 illegal single-beat pkts with CNT_W=8 -> drop_cnt=255, holds.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// Shared definitions for the stream demux and its round-robin arbiter sibling:
// FSM state encoding and the destination-index width rule.
package stream_demux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  // Destination index width for n ports: max(1, clog2(n)).
  function automatic int dest_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_demux_skid_buffer.sv
// Skid stage with a registered upstream ready. When empty, beats pass straight through;
// a beat arriving while the consumer stalls is parked here and ready drops.
module skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         skid_vld_p0;
  logic [W-1:0] skid_data_p0;
  logic         skid_vld_nxt;
  logic         park;

  assign park = !skid_vld_p0 && in_valid && in_ready && !out_ready;

  always_comb begin
    skid_vld_nxt = skid_vld_p0;
    if (skid_vld_p0) begin
      if (out_ready) skid_vld_nxt = 1'b0;
    end else if (park) begin
      skid_vld_nxt = 1'b1;
    end
  end

  // The parked beat always takes priority, which keeps order intact.
  assign out_valid = skid_vld_p0 | (in_valid & in_ready);
  assign out_data  = skid_vld_p0 ? skid_data_p0 : in_data;

  // ---- stage p0: skid entry and registered ready ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_vld_p0 <= 1'b0;
      in_ready    <= 1'b0;
    end else begin
      skid_vld_p0 <= skid_vld_nxt;
      in_ready    <= !skid_vld_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (park) skid_data_p0 <= in_data;
  end

endmodule

// File: rtl/stream_demux.sv
// 1:N packet router: steers each whole packet to the port named on its first beat,
// drops packets whose destination does not exist and counts them.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int REQ_WIDTH = 4,
  parameter int DW        = 8,
  parameter int DEST_W    = dest_width(REQ_WIDTH),
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  output logic                 ready_out,
  input  logic [DW-1:0]        data_in,
  input  logic [DEST_W-1:0]    dest_in,
  input  logic                 last_in,
  output logic [REQ_WIDTH-1:0] valid_out,
  input  logic [REQ_WIDTH-1:0] ready_in,
  output logic [DW-1:0]        data_out,
  output logic                 last_out,
  output logic [CNT_W-1:0]     drop_cnt
);

  localparam int SW = DEST_W + 1 + DW;
  localparam logic [REQ_WIDTH-1:0] ONE = {{(REQ_WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic              sb_valid;
  logic              sb_ready;
  logic [SW-1:0]     sb_data;
  logic [DEST_W-1:0] dest_p0;
  logic              last_p0;
  logic [DW-1:0]     data_p0;

  skid_buffer #(.W(SW)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (valid_in),
    .in_ready  (ready_out),
    .in_data   ({dest_in, last_in, data_in}),
    .out_valid (sb_valid),
    .out_ready (sb_ready),
    .out_data  (sb_data)
  );

  assign {dest_p0, last_p0, data_p0} = sb_data;

  state_t            state;
  logic              vld_p1;
  logic [DEST_W-1:0] sel_p1;
  logic [DW-1:0]     data_p1;
  logic              last_p1;
  logic              illegal;
  logic              dropping;
  logic              out_free;
  logic              mv;

  assign illegal  = (int'(dest_p0) >= REQ_WIDTH);
  // Dropped beats never need the output register, so they drain even under a stalled sink.
  assign dropping = (state == ST_DROP) || ((state == ST_IDLE) && illegal);
  assign out_free = !vld_p1 || ready_in[sel_p1];
  assign sb_ready = dropping || out_free;
  assign mv       = sb_valid && sb_ready;

  // ---- stage p1: routing FSM, output register, drop counter ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      vld_p1   <= 1'b0;
      sel_p1   <= '0;
      data_p1  <= '0;
      last_p1  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (vld_p1 && ready_in[sel_p1]) vld_p1 <= 1'b0;
      if (mv) begin
        case (state)
          ST_IDLE: begin
            if (illegal) begin
              drop_cnt <= sat_inc(drop_cnt);
              if (!last_p0) state <= ST_DROP;
            end else begin
              sel_p1  <= dest_p0;
              vld_p1  <= 1'b1;
              data_p1 <= data_p0;
              last_p1 <= last_p0;
              if (!last_p0) state <= ST_BUSY;
            end
          end
          ST_BUSY: begin
            vld_p1  <= 1'b1;
            data_p1 <= data_p0;
            last_p1 <= last_p0;
            if (last_p0) state <= ST_IDLE;
          end
          ST_DROP: begin
            if (last_p0) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign valid_out = vld_p1 ? (ONE << sel_p1) : '0;
  assign data_out  = data_p1;
  assign last_out  = vld_p1 & last_p1;

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: a 4-port and a 3-port instance driven with directed and random
// packets, checked against a packet-level routing model.
module tb_stream_demux;

  logic       clk = 1'b0;
  logic       rst;
  logic       v4, l4, r4, lo4;
  logic [7:0] d4, do4, dc4;
  logic [1:0] t4;
  logic [3:0] vo4, ri4;
  logic       v3, l3, r3, lo3;
  logic [7:0] d3, do3, dc3;
  logic [1:0] t3;
  logic [2:0] vo3, ri3;

  always #5 clk = ~clk;

  stream_demux #(.REQ_WIDTH(4), .DW(8), .DEST_W(2), .CNT_W(8)) u4 (
    .clk(clk), .rst(rst), .valid_in(v4), .ready_out(r4), .data_in(d4), .dest_in(t4),
    .last_in(l4), .valid_out(vo4), .ready_in(ri4), .data_out(do4), .last_out(lo4),
    .drop_cnt(dc4));

  stream_demux #(.REQ_WIDTH(3), .DW(8), .DEST_W(2), .CNT_W(8)) u3 (
    .clk(clk), .rst(rst), .valid_in(v3), .ready_out(r3), .data_in(d3), .dest_in(t3),
    .last_in(l3), .valid_out(vo3), .ready_in(ri3), .data_out(do3), .last_out(lo3),
    .drop_cnt(dc3));

  typedef struct packed {
    logic [1:0] port;
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t exp4[$], obs4[$], exp3[$], obs3[$];
  int    idx4 = 0, idx3 = 0;
  int    onehot_bad = 0;
  int    total = 0, bad = 0;
  int    exp_drop3 = 0;
  bit    inpkt[2];
  int    cur_dest[2];
  int    sink_mode = 0;

  // Records every completed downstream transfer.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        if ($countones(vo4) > 1 || $countones(vo3) > 1) onehot_bad++;
        for (int i = 0; i < 4; i++)
          if (vo4[i] && ri4[i]) obs4.push_back('{port: 2'(i), data: do4, last: lo4});
        for (int i = 0; i < 3; i++)
          if (vo3[i] && ri3[i]) obs3.push_back('{port: 2'(i), data: do3, last: lo3});
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    case (sink_mode)
      1: begin ri4 = 4'($urandom); ri3 = 3'($urandom); end
      2: begin ri4 = ~ri4; ri3 = ~ri3; end
      default: ;
    endcase
  endtask

  // Offers one beat and waits (bounded) for acceptance; updates the routing model.
  task automatic send(input int which, input logic [7:0] dat, input logic [1:0] dst,
                      input logic lst, output int waits);
    bit acc;
    int k, np;
    waits = 0;
    acc = 1'b0;
    if (which == 4) begin v4 = 1'b1; d4 = dat; t4 = dst; l4 = lst; end
    else            begin v3 = 1'b1; d3 = dat; t3 = dst; l3 = lst; end
    forever begin
      @(negedge clk);
      acc = (which == 4) ? r4 : r3;
      tick();
      if (acc) break;
      waits++;
      if (waits > 300) break;
    end
    v4 = 1'b0;
    v3 = 1'b0;
    chk("accept", 32'(acc), 32'd1);
    if (acc) begin
      k  = (which == 4) ? 0 : 1;
      np = (which == 4) ? 4 : 3;
      if (!inpkt[k]) cur_dest[k] = int'(dst);
      if (cur_dest[k] < np) begin
        if (which == 4) exp4.push_back('{port: 2'(cur_dest[k]), data: dat, last: lst});
        else            exp3.push_back('{port: 2'(cur_dest[k]), data: dat, last: lst});
      end else if (!inpkt[k] && exp_drop3 < 255) begin
        exp_drop3++;
      end
      inpkt[k] = !lst;
    end
  endtask

  task automatic send_pkt(input int which, input logic [1:0] dst, input int n);
    int w;
    for (int i = 0; i < n; i++)
      send(which, 8'($urandom), (i == 0) ? dst : 2'($urandom), (i == n - 1), w);
    if ($urandom_range(0, 1) == 1) tick();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    sink_mode = 0;
    ri4 = '1;
    ri3 = '1;
    while ((obs4.size() < exp4.size() || obs3.size() < exp3.size() || vo4 != 0 || vo3 != 0)
           && n < 400) begin
      tick();
      n++;
    end
    tick();
    tick();
    chk({tag, "_count4"}, 32'(obs4.size()), 32'(exp4.size()));
    for (int i = idx4; i < exp4.size(); i++)
      if (i < obs4.size()) chk({tag, "_beat4"}, 32'(obs4[i]), 32'(exp4[i]));
    idx4 = exp4.size();
    chk({tag, "_count3"}, 32'(obs3.size()), 32'(exp3.size()));
    for (int i = idx3; i < exp3.size(); i++)
      if (i < obs3.size()) chk({tag, "_beat3"}, 32'(obs3[i]), 32'(exp3[i]));
    idx3 = exp3.size();
    chk({tag, "_onehot"}, 32'(onehot_bad), 32'd0);
    chk({tag, "_drop3"}, 32'(dc3), 32'(exp_drop3));
    chk({tag, "_drop4"}, 32'(dc4), 32'd0);
  endtask

  initial begin
    int w, sumw;
    rst = 1'b1;
    v4 = 1'b0; d4 = '0; t4 = '0; l4 = 1'b0; ri4 = '1;
    v3 = 1'b0; d3 = '0; t3 = '0; l3 = 1'b0; ri3 = '1;
    #12;
    chk("rst_ready", 32'({r4, r3}), 32'd0);
    chk("rst_valid", 32'({vo4, vo3}), 32'd0);
    chk("rst_data", 32'({do4, do3}), 32'd0);
    chk("rst_last", 32'({lo4, lo3}), 32'd0);
    chk("rst_drop", 32'({dc4, dc3}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    chk("ready_after_rst", 32'({r4, r3}), 32'd3);

    // Single-beat packet to port 2.
    send(4, 8'hA5, 2'd2, 1'b1, w);
    chk("t1_valid", 32'(vo4), 32'b0100);
    chk("t1_data", 32'(do4), 32'hA5);
    chk("t1_last", 32'(lo4), 32'd1);
    chk("t1_drop", 32'(dc4), 32'd0);
    tick();
    chk("t1_idle", 32'(vo4), 32'd0);
    drain("t1");

    // Multi-beat packet; dest on later beats must be ignored.
    send(4, 8'h11, 2'd1, 1'b0, w);
    send(4, 8'h22, 2'd3, 1'b0, w);
    chk("t2_valid", 32'(vo4), 32'b0010);
    chk("t2_data", 32'(do4), 32'h22);
    chk("t2_last", 32'(lo4), 32'd0);
    send(4, 8'h33, 2'd3, 1'b1, w);
    drain("t2");

    // Stalled sink: output plus skid hold two beats, then ready drops.
    ri4 = 4'b1110;
    send(4, 8'h40, 2'd0, 1'b0, w);
    send(4, 8'h41, 2'd0, 1'b0, w);
    chk("t3_full", 32'(r4), 32'd0);
    repeat (3) tick();
    chk("t3_hold_ready", 32'(r4), 32'd0);
    chk("t3_hold_valid", 32'(vo4), 32'b0001);
    chk("t3_hold_data", 32'(do4), 32'h40);
    ri4 = '1;
    send(4, 8'h42, 2'd0, 1'b0, w);
    send(4, 8'h43, 2'd0, 1'b1, w);
    drain("t3");

    // Illegal destination on the 3-port instance, then a legal packet.
    send(3, 8'h01, 2'd3, 1'b0, w);
    send(3, 8'h02, 2'd1, 1'b1, w);
    send(3, 8'h77, 2'd0, 1'b1, w);
    tick();
    chk("t4_drop", 32'(dc3), 32'd1);
    drain("t4");

    // Back-to-back single-beat packets to different ports with no bubble.
    sumw = 0;
    for (int p = 0; p < 4; p++) begin
      send(4, 8'(8'h80 + p), 2'(p), 1'b1, w);
      sumw += w;
      chk("b2b_valid", 32'(vo4), 32'(4'b0001 << p));
    end
    chk("b2b_waits", 32'(sumw), 32'd0);
    drain("b2b");

    // Reset in the middle of a packet.
    send(4, 8'h51, 2'd1, 1'b0, w);
    send(4, 8'h52, 2'd1, 1'b0, w);
    rst = 1'b1;
    #1;
    chk("t5_valid", 32'(vo4), 32'd0);
    chk("t5_data", 32'(do4), 32'd0);
    chk("t5_last", 32'(lo4), 32'd0);
    chk("t5_ready", 32'(r4), 32'd0);
    void'(exp4.pop_back());
    inpkt[0] = 1'b0;
    inpkt[1] = 1'b0;
    exp_drop3 = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    chk("t5_ready_up", 32'(r4), 32'd1);
    send(4, 8'h60, 2'd3, 1'b1, w);
    chk("t5_route", 32'(vo4), 32'b1000);
    chk("t5_route_data", 32'(do4), 32'h60);
    drain("t5");

    // Random packets against a random and a toggling sink.
    sink_mode = 1;
    for (int i = 0; i < 30; i++) send_pkt(4, 2'($urandom), $urandom_range(1, 4));
    drain("rnd4");
    ri4 = 4'b0101;
    sink_mode = 2;
    for (int i = 0; i < 20; i++) send_pkt(4, 2'($urandom), $urandom_range(1, 4));
    drain("tog4");
    sink_mode = 1;
    for (int i = 0; i < 30; i++) send_pkt(3, 2'($urandom), $urandom_range(1, 4));
    drain("rnd3");

    // Drop counter saturation.
    for (int i = 0; i < 300; i++) send(3, 8'(i), 2'd3, 1'b1, w);
    tick();
    chk("t6_sat", 32'(dc3), 32'hFF);
    for (int i = 0; i < 5; i++) send(3, 8'(i), 2'd3, 1'b1, w);
    tick();
    chk("t6_hold", 32'(dc3), 32'hFF);
    drain("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
